// File: rtl/holy_core_pkg.sv
// Shared encodings for the HOLY core: opcodes, function fields, ALU ops,
// immediate formats, control bundle, sequencer state and trap causes.
package holy_core_pkg;

  localparam logic [6:0] OPCODE_R_TYPE       = 7'b0110011;
  localparam logic [6:0] OPCODE_I_TYPE_ALU   = 7'b0010011;
  localparam logic [6:0] OPCODE_I_TYPE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_S_TYPE       = 7'b0100011;
  localparam logic [6:0] OPCODE_B_TYPE       = 7'b1100011;
  localparam logic [6:0] OPCODE_J_TYPE       = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR         = 7'b1100111;
  localparam logic [6:0] OPCODE_U_TYPE_LUI   = 7'b0110111;
  localparam logic [6:0] OPCODE_U_TYPE_AUIPC = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [3:0] CAUSE_NONE          = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL_INSTR = 4'd2;
  localparam logic [3:0] CAUSE_LOAD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_STORE_FAULT   = 4'd7;

  typedef enum logic [1:0] {
    EXEC     = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } ctrl_state_t;

  // Datapath select fields; the enables are gated separately by the sequencer
  typedef struct packed {
    logic [3:0] alu_control;
    logic [2:0] imm_source;
    logic       alu_source;
    logic [1:0] write_back_source;
    logic [1:0] second_add_source;
  } ctrl_t;

endpackage

// File: rtl/control_decoder.sv
// Combinational instruction decoder: op/func3/func7 to datapath selects plus
// instruction-class flags for the sequencer.
module control_decoder
  import holy_core_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output ctrl_t      ctrl,
  output logic       reg_write,
  output logic       is_load,
  output logic       is_store,
  output logic       is_illegal,
  output logic       branch,
  output logic       jump
);

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD_SUB: alu_decode = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     alu_decode = ALU_SLL;
      F3_SLT:     alu_decode = ALU_SLT;
      F3_SLTU:    alu_decode = ALU_SLTU;
      F3_XOR:     alu_decode = ALU_XOR;
      F3_SRL_SRA: alu_decode = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      alu_decode = ALU_OR;
      default:    alu_decode = ALU_AND;
    endcase
  endfunction

  always_comb begin
    ctrl       = '0;
    reg_write  = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_illegal = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    case (op)
      OPCODE_R_TYPE: begin
        reg_write        = 1'b1;
        ctrl.alu_control = alu_decode(func3, func7 == F7_ALT);
        // Only sub and sra use the alternate func7
        is_illegal = !((func7 == F7_BASE) ||
                       (func7 == F7_ALT && (func3 == F3_ADD_SUB || func3 == F3_SRL_SRA)));
      end
      OPCODE_I_TYPE_ALU: begin
        reg_write        = 1'b1;
        ctrl.alu_source  = 1'b1;
        ctrl.imm_source  = IMM_I;
        ctrl.alu_control = alu_decode(func3, (func3 == F3_SRL_SRA) && (func7 == F7_ALT));
        if (func3 == F3_SLL)
          is_illegal = (func7 != F7_BASE);
        else if (func3 == F3_SRL_SRA)
          is_illegal = (func7 != F7_BASE) && (func7 != F7_ALT);
      end
      OPCODE_I_TYPE_LOAD: begin
        reg_write              = 1'b1;
        is_load                = 1'b1;
        ctrl.alu_source        = 1'b1;
        ctrl.imm_source        = IMM_I;
        ctrl.write_back_source = 2'b01;
      end
      OPCODE_S_TYPE: begin
        is_store        = 1'b1;
        ctrl.alu_source = 1'b1;
        ctrl.imm_source = IMM_S;
      end
      OPCODE_B_TYPE: begin
        branch          = 1'b1;
        ctrl.imm_source = IMM_B;
        case (func3)
          F3_BEQ, F3_BNE:   ctrl.alu_control = ALU_SUB;
          F3_BLT, F3_BGE:   ctrl.alu_control = ALU_SLT;
          F3_BLTU, F3_BGEU: ctrl.alu_control = ALU_SLTU;
          default:          ctrl.alu_control = ALU_SUB;
        endcase
      end
      OPCODE_J_TYPE: begin
        reg_write              = 1'b1;
        jump                   = 1'b1;
        ctrl.imm_source        = IMM_J;
        ctrl.write_back_source = 2'b10;
        ctrl.second_add_source = 2'b00;
      end
      OPCODE_JALR: begin
        reg_write              = 1'b1;
        jump                   = 1'b1;
        ctrl.alu_source        = 1'b1;
        ctrl.imm_source        = IMM_I;
        ctrl.write_back_source = 2'b10;
        ctrl.second_add_source = 2'b10;
      end
      OPCODE_U_TYPE_LUI: begin
        reg_write              = 1'b1;
        ctrl.imm_source        = IMM_U;
        ctrl.write_back_source = 2'b11;
        ctrl.second_add_source = 2'b01;
      end
      OPCODE_U_TYPE_AUIPC: begin
        reg_write              = 1'b1;
        ctrl.imm_source        = IMM_U;
        ctrl.write_back_source = 2'b11;
        ctrl.second_add_source = 2'b00;
      end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_seq.sv
// Sequenced control unit: single-cycle decode for ALU/branch/jump ops, a
// valid/ack handshake with timeout for loads/stores, and trap raising.
module control_seq
  import holy_core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter bit TRAP_EN        = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instruction,
  input  logic        alu_zero,
  input  logic        alu_last_bit,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic        trap_ack,
  output logic [3:0]  alu_control,
  output logic [2:0]  imm_source,
  output logic        alu_source,
  output logic [1:0]  write_back_source,
  output logic [1:0]  second_add_source,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        pc_source,
  output logic        pc_write_enable,
  output logic        stall,
  output logic        trap,
  output logic [3:0]  trap_cause
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       cause_q;

  ctrl_t dec_ctrl;
  logic  dec_reg_write, dec_is_load, dec_is_store, dec_is_illegal, dec_branch, dec_jump;

  // Captured decode of the memory instruction, held across MEM_WAIT
  ctrl_t sel_p0;
  logic  is_load_p0, is_store_p0;

  ctrl_t sel;
  logic  taken, timeout_hit, fault;
  logic  unused_instr;

  assign unused_instr = ^{instruction[24:15], instruction[11:7]};

  control_decoder u_decoder (
    .op         (instruction[6:0]),
    .func3      (instruction[14:12]),
    .func7      (instruction[31:25]),
    .ctrl       (dec_ctrl),
    .reg_write  (dec_reg_write),
    .is_load    (dec_is_load),
    .is_store   (dec_is_store),
    .is_illegal (dec_is_illegal),
    .branch     (dec_branch),
    .jump       (dec_jump)
  );

  always_comb begin
    case (instruction[14:12])
      F3_BEQ:           taken = alu_zero;
      F3_BNE:           taken = !alu_zero;
      F3_BLT, F3_BLTU:  taken = alu_last_bit;
      F3_BGE, F3_BGEU:  taken = !alu_last_bit;
      default:          taken = 1'b0;
    endcase
  end

  assign timeout_hit = (cnt_q == CNT_LAST);
  assign fault       = mem_err || (!mem_ack && timeout_hit);

  always_comb begin
    sel             = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    reg_write       = 1'b0;
    pc_source       = 1'b0;
    pc_write_enable = 1'b0;
    stall           = 1'b0;
    trap            = 1'b0;
    if (!rst) begin
      case (state_q)
        EXEC: begin
          if (instr_valid) begin
            if (dec_is_illegal) begin
              if (TRAP_EN) stall = 1'b1;
              else         pc_write_enable = 1'b1;
            end else if (dec_is_load || dec_is_store) begin
              sel       = dec_ctrl;
              mem_read  = dec_is_load;
              mem_write = dec_is_store;
              stall     = 1'b1;
            end else begin
              sel             = dec_ctrl;
              reg_write       = dec_reg_write;
              pc_write_enable = 1'b1;
              pc_source       = (dec_branch && taken) || dec_jump;
            end
          end
        end
        MEM_WAIT: begin
          sel       = sel_p0;
          mem_read  = is_load_p0;
          mem_write = is_store_p0;
          if (fault) begin
            if (TRAP_EN) stall = 1'b1;
            else         pc_write_enable = 1'b1;
          end else if (mem_ack) begin
            reg_write       = is_load_p0;
            pc_write_enable = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end
        TRAP: begin
          trap  = 1'b1;
          stall = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign alu_control       = sel.alu_control;
  assign imm_source        = sel.imm_source;
  assign alu_source        = sel.alu_source;
  assign write_back_source = sel.write_back_source;
  assign second_add_source = sel.second_add_source;
  assign trap_cause        = rst ? CAUSE_NONE : cause_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EXEC;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      case (state_q)
        EXEC: begin
          if (instr_valid) begin
            if (dec_is_illegal) begin
              if (TRAP_EN) begin
                state_q <= TRAP;
                cause_q <= CAUSE_ILLEGAL_INSTR;
              end
            end else if (dec_is_load || dec_is_store) begin
              state_q <= MEM_WAIT;
              cnt_q   <= '0;
            end
          end
        end
        MEM_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (fault) begin
            if (TRAP_EN) begin
              state_q <= TRAP;
              cause_q <= is_load_p0 ? CAUSE_LOAD_FAULT : CAUSE_STORE_FAULT;
            end else begin
              state_q <= EXEC;
            end
          end else if (mem_ack) begin
            state_q <= EXEC;
          end
        end
        TRAP: begin
          if (trap_ack) begin
            state_q <= EXEC;
            cause_q <= CAUSE_NONE;
          end
        end
        default: state_q <= EXEC;
      endcase
    end
  end

  // Capture stage: decode of an accepted memory op, no reset needed
  always_ff @(posedge clk) begin
    if (state_q == EXEC && instr_valid) begin
      sel_p0      <= dec_ctrl;
      is_load_p0  <= dec_is_load;
      is_store_p0 <= dec_is_store;
    end
  end

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq: vector table for single-cycle ops plus
// hand sequences for the memory handshake, timeout, traps and reset.
module tb_control_seq;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd4, A_SLT = 4'd5;
  localparam logic [3:0] A_SLTU = 4'd7, A_SRA = 4'd9;
  localparam logic [31:0] I_ADD = 32'h003100B3, I_LW = 32'h00012083, I_SW = 32'h00312023;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        alu_zero, alu_last_bit, mem_ack, mem_err, trap_ack;

  logic [3:0] alu1, alu2, cause1, cause2;
  logic [2:0] imm1, imm2;
  logic [1:0] wb1, wb2, sa1, sa2;
  logic asrc1, asrc2, mr1, mr2, mw1, mw2, rw1, rw2, pcs1, pcs2, pcwe1, pcwe2;
  logic st1, st2, tr1, tr2;

  logic [18:0] s1, s2;
  assign s1 = {rw1, pcwe1, pcs1, st1, mr1, mw1, tr1, alu1, imm1, asrc1, wb1, sa1};
  assign s2 = {rw2, pcwe2, pcs2, st2, mr2, mw2, tr2, alu2, imm2, asrc2, wb2, sa2};

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  control_seq #(.TIMEOUT_CYCLES(4), .TRAP_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
    .alu_zero(alu_zero), .alu_last_bit(alu_last_bit), .mem_ack(mem_ack),
    .mem_err(mem_err), .trap_ack(trap_ack), .alu_control(alu1), .imm_source(imm1),
    .alu_source(asrc1), .write_back_source(wb1), .second_add_source(sa1),
    .mem_read(mr1), .mem_write(mw1), .reg_write(rw1), .pc_source(pcs1),
    .pc_write_enable(pcwe1), .stall(st1), .trap(tr1), .trap_cause(cause1)
  );

  control_seq #(.TIMEOUT_CYCLES(4), .TRAP_EN(1'b0)) dut_nt (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
    .alu_zero(alu_zero), .alu_last_bit(alu_last_bit), .mem_ack(mem_ack),
    .mem_err(mem_err), .trap_ack(trap_ack), .alu_control(alu2), .imm_source(imm2),
    .alu_source(asrc2), .write_back_source(wb2), .second_add_source(sa2),
    .mem_read(mr2), .mem_write(mw2), .reg_write(rw2), .pc_source(pcs2),
    .pc_write_enable(pcwe2), .stall(st2), .trap(tr2), .trap_cause(cause2)
  );

  // {reg_write, pc_we, pc_source, stall, mem_read, mem_write, trap, alu, imm, alu_src, wb, second_add}
  function automatic logic [18:0] e(input logic rw, pcwe, pcs, stl, mr, mw, tr,
                                    input logic [3:0] alu, input logic [2:0] imm,
                                    input logic as, input logic [1:0] wb, sa);
    return {rw, pcwe, pcs, stl, mr, mw, tr, alu, imm, as, wb, sa};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        az;
    logic        alb;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[14];

  logic [18:0] lw_req, sw_req, trap_out, ill_te, ill_nt;
  logic [31:0] illegal_instrs[3];
  int nrd, nst;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"add",     32'h003100B3, 0, 0, e(1,1,0,0,0,0,0,A_ADD, 3'd0,0,2'd0,2'd0)};
    vecs[1]  = '{"sub",     32'h403100B3, 0, 0, e(1,1,0,0,0,0,0,A_SUB, 3'd0,0,2'd0,2'd0)};
    vecs[2]  = '{"addi",    32'h00510093, 0, 0, e(1,1,0,0,0,0,0,A_ADD, 3'd0,1,2'd0,2'd0)};
    vecs[3]  = '{"slli",    32'h00311093, 0, 0, e(1,1,0,0,0,0,0,A_SLL, 3'd0,1,2'd0,2'd0)};
    vecs[4]  = '{"srai",    32'h40315093, 0, 0, e(1,1,0,0,0,0,0,A_SRA, 3'd0,1,2'd0,2'd0)};
    vecs[5]  = '{"beq_tk",  32'h00208063, 1, 0, e(0,1,1,0,0,0,0,A_SUB, 3'd2,0,2'd0,2'd0)};
    vecs[6]  = '{"bne_nt",  32'h00209063, 1, 0, e(0,1,0,0,0,0,0,A_SUB, 3'd2,0,2'd0,2'd0)};
    vecs[7]  = '{"bne_tk",  32'h00209063, 0, 0, e(0,1,1,0,0,0,0,A_SUB, 3'd2,0,2'd0,2'd0)};
    vecs[8]  = '{"blt_tk",  32'h0020C063, 0, 1, e(0,1,1,0,0,0,0,A_SLT, 3'd2,0,2'd0,2'd0)};
    vecs[9]  = '{"bgeu_nt", 32'h0020F063, 0, 1, e(0,1,0,0,0,0,0,A_SLTU,3'd2,0,2'd0,2'd0)};
    vecs[10] = '{"jal",     32'h000000EF, 0, 0, e(1,1,1,0,0,0,0,A_ADD, 3'd3,0,2'd2,2'd0)};
    vecs[11] = '{"jalr",    32'h000100E7, 0, 0, e(1,1,1,0,0,0,0,A_ADD, 3'd0,1,2'd2,2'd2)};
    vecs[12] = '{"lui",     32'h000010B7, 0, 0, e(1,1,0,0,0,0,0,A_ADD, 3'd4,0,2'd3,2'd1)};
    vecs[13] = '{"auipc",   32'h00001097, 0, 0, e(1,1,0,0,0,0,0,A_ADD, 3'd4,0,2'd3,2'd0)};

    lw_req   = e(0,0,0,1,1,0,0,A_ADD,3'd0,1,2'd1,2'd0);
    sw_req   = e(0,0,0,1,0,1,0,A_ADD,3'd1,1,2'd0,2'd0);
    trap_out = e(0,0,0,1,0,0,1,A_ADD,3'd0,0,2'd0,2'd0);
    ill_te   = e(0,0,0,1,0,0,0,A_ADD,3'd0,0,2'd0,2'd0);
    ill_nt   = e(0,1,0,0,0,0,0,A_ADD,3'd0,0,2'd0,2'd0);
    illegal_instrs[0] = 32'h0000007F;
    illegal_instrs[1] = 32'h40311093;
    illegal_instrs[2] = 32'h023100B3;

    rst = 1'b1; instr_valid = 1'b0; instruction = '0;
    alu_zero = 1'b0; alu_last_bit = 1'b0; mem_ack = 1'b0; mem_err = 1'b0; trap_ack = 1'b0;
    cyc(); cyc();
    instruction = I_ADD; instr_valid = 1'b1; #1;
    chk("reset_outputs", 32'(s1), 32'd0);
    chk("reset_outputs_nt", 32'(s2), 32'd0);
    chk("reset_cause", 32'(cause1), 32'd0);
    cyc();
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      instruction = vecs[i].instr; alu_zero = vecs[i].az; alu_last_bit = vecs[i].alb;
      instr_valid = 1'b1; #1;
      chk(vecs[i].name, 32'(s1), 32'(vecs[i].exp));
      chk({vecs[i].name, "_nt"}, 32'(s2), 32'(vecs[i].exp));
      cyc();
    end
    alu_zero = 1'b0; alu_last_bit = 1'b0;

    // trap_ack outside TRAP has no effect
    instruction = I_ADD; trap_ack = 1'b1; #1;
    chk("ack_in_exec", 32'(s1), 32'(vecs[0].exp));
    cyc();
    trap_ack = 1'b0; instr_valid = 1'b0; #1;
    chk("idle", 32'(s1), 32'd0);
    chk("idle_cause", 32'(cause1), 32'd0);
    cyc();

    // lw acked on the third MEM_WAIT cycle
    instruction = I_LW; instr_valid = 1'b1;
    nrd = 0; nst = 0;
    for (int c = 0; c < 5; c++) begin
      mem_ack = (c == 3);
      if (c == 4) instr_valid = 1'b0;
      #1;
      nrd += int'(mr1); nst += int'(st1);
      if (c < 3)       chk("lw_wait", 32'(s1), 32'(lw_req));
      else if (c == 3) chk("lw_ack", 32'(s1), 32'(e(1,1,0,0,1,0,0,A_ADD,3'd0,1,2'd1,2'd0)));
      else             chk("lw_done", 32'(s1), 32'd0);
      cyc();
    end
    mem_ack = 1'b0;
    chk("lw_read_cycles", 32'(nrd), 32'd4);
    chk("lw_stall_cycles", 32'(nst), 32'd3);

    // sw never acked: timeout after four MEM_WAIT cycles
    instruction = I_SW; instr_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("sw_wait", 32'(s1), 32'(sw_req));
      if (c == 4) chk("sw_timeout_nt", 32'(s2), 32'(e(0,1,0,0,0,1,0,A_ADD,3'd1,1,2'd0,2'd0)));
      cyc();
    end
    instr_valid = 1'b0; #1;
    chk("sw_trap", 32'(s1), 32'(trap_out));
    chk("sw_cause", 32'(cause1), 32'd7);
    chk("sw_nt_idle", 32'(s2), 32'd0);
    cyc();
    chk("sw_trap_held", 32'(s1), 32'(trap_out));
    trap_ack = 1'b1; #1;
    chk("sw_trap_ack_cycle", 32'(tr1), 32'd1);
    cyc();
    trap_ack = 1'b0; #1;
    chk("sw_after_ack", 32'(s1), 32'd0);
    chk("sw_cause_clear", 32'(cause1), 32'd0);
    cyc();

    // lw with err and ack together: error wins
    instruction = I_LW; instr_valid = 1'b1; #1;
    chk("lwerr_issue", 32'(s1), 32'(lw_req));
    cyc();
    mem_ack = 1'b1; mem_err = 1'b1; #1;
    chk("lwerr_cycle", 32'(s1), 32'(lw_req));
    chk("lwerr_cycle_nt", 32'(s2), 32'(e(0,1,0,0,1,0,0,A_ADD,3'd0,1,2'd1,2'd0)));
    cyc();
    mem_ack = 1'b0; mem_err = 1'b0; instr_valid = 1'b0; #1;
    chk("lwerr_trap", 32'(s1), 32'(trap_out));
    chk("lwerr_cause", 32'(cause1), 32'd5);
    chk("lwerr_nt_idle", 32'(s2), 32'd0);
    trap_ack = 1'b1;
    cyc();
    trap_ack = 1'b0;

    // illegal instructions
    for (int k = 0; k < 3; k++) begin
      instruction = illegal_instrs[k]; instr_valid = 1'b1; #1;
      chk("ill_exec", 32'(s1), 32'(ill_te));
      chk("ill_exec_nt", 32'(s2), 32'(ill_nt));
      cyc();
      instr_valid = 1'b0; #1;
      chk("ill_trap", 32'(s1), 32'(trap_out));
      chk("ill_cause", 32'(cause1), 32'd2);
      trap_ack = 1'b1;
      cyc();
      trap_ack = 1'b0; #1;
      chk("ill_after_ack", 32'(s1), 32'd0);
      cyc();
    end

    // reset in the middle of MEM_WAIT
    instruction = I_LW; instr_valid = 1'b1;
    cyc();
    chk("rst_mw_wait", 32'(s1), 32'(lw_req));
    rst = 1'b1; instr_valid = 1'b0; #1;
    chk("rst_mw_gated", 32'(s1), 32'd0);
    cyc();
    rst = 1'b0; #1;
    chk("rst_mw_after", 32'(s1), 32'd0);
    instruction = I_ADD; instr_valid = 1'b1; #1;
    chk("rst_mw_exec", 32'(s1), 32'(vecs[0].exp));
    cyc();
    instr_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
